// File: rtl/exec_sequencer_if.sv
// Debug command handshake between the debug host and the run-control sequencer.
// The host drives valid/op; the sequencer answers with ready.
interface exec_sequencer_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i;

    modport master (
        output cmd_valid_i,
        output cmd_op_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i,
        input  cmd_op_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/exec_sequencer.sv
// Run-control sequencer: gates fetch/pipeline advance, executes debug commands,
// drains the pipeline on halt and keeps cycle / retired-instruction counters.
module exec_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    exec_sequencer_if.slave  cmd,
    input  logic             wb_is_halt_i,
    input  logic             wb_retire_i,
    output logic             fetch_en_o,
    output logic             pipe_en_o,
    output logic             core_flush_o,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic [1:0]       halt_cause_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RUN      = 3'd1;
    localparam logic [2:0] S_STEP     = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_HALTED   = 3'd4;
    localparam logic [2:0] S_CORE_RST = 3'd5;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_HALT  = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_ECALL = 2'b01;
    localparam logic [1:0] C_DEBUG = 2'b10;
    localparam logic [1:0] C_STEP  = 2'b11;

    logic [2:0]       state_q,   state_d;
    logic [1:0]       cause_q,   cause_d;
    logic [DW-1:0]    drain_q,   drain_d;
    logic             from_step_q, from_step_d;
    logic [CNT_W-1:0] cycle_q,   cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic ready;
    logic pipe_en;
    logic accept;
    logic ecall;

    assign ready   = (state_q == S_IDLE) || (state_q == S_RUN) ||
                     (state_q == S_HALTED);
    assign pipe_en = (state_q == S_RUN) || (state_q == S_STEP) ||
                     (state_q == S_DRAIN);
    assign accept  = cmd.cmd_valid_i && ready;
    assign ecall   = wb_is_halt_i && pipe_en;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        drain_d     = drain_q;
        from_step_d = from_step_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (cmd.cmd_op_i)
                        OP_RUN:   begin state_d = S_RUN;  cause_d = C_NONE; end
                        OP_STEP:  begin state_d = S_STEP; cause_d = C_NONE; end
                        OP_RESET: state_d = S_CORE_RST;
                        default:  ;
                    endcase
                end
            end
            S_RUN: begin
                if (ecall) begin
                    state_d = S_HALTED;
                    cause_d = C_ECALL;
                end else if (accept) begin
                    unique case (cmd.cmd_op_i)
                        OP_HALT: begin
                            state_d     = S_DRAIN;
                            drain_d     = DW'(DRAIN_CYCLES);
                            from_step_d = 1'b0;
                        end
                        OP_RESET: state_d = S_CORE_RST;
                        default:  ;
                    endcase
                end
            end
            S_STEP: begin
                if (ecall) begin
                    state_d = S_HALTED;
                    cause_d = C_ECALL;
                end else begin
                    state_d     = S_DRAIN;
                    drain_d     = DW'(DRAIN_CYCLES);
                    from_step_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // An ecall reaching WB wins over a drain that is just finishing
                if (ecall) begin
                    state_d = S_HALTED;
                    cause_d = C_ECALL;
                    drain_d = '0;
                end else if (drain_q <= DW'(1)) begin
                    state_d = S_HALTED;
                    cause_d = from_step_q ? C_STEP : C_DEBUG;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_HALTED: begin
                if (accept) begin
                    if (cmd.cmd_op_i == OP_RESET) begin
                        state_d = S_CORE_RST;
                    end else if (cause_q != C_ECALL) begin
                        if (cmd.cmd_op_i == OP_RUN) begin
                            state_d = S_RUN;
                            cause_d = C_NONE;
                        end else if (cmd.cmd_op_i == OP_STEP) begin
                            state_d = S_STEP;
                            cause_d = C_NONE;
                        end
                    end
                end
            end
            S_CORE_RST: begin
                state_d = S_IDLE;
                cause_d = C_NONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (pipe_en) begin
            cycle_d = cycle_q + CNT_W'(1);
            if (wb_retire_i) instret_d = instret_q + CNT_W'(1);
        end
        if (state_q == S_CORE_RST) begin
            cycle_d   = '0;
            instret_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cause_q     <= C_NONE;
            drain_q     <= '0;
            from_step_q <= 1'b0;
            cycle_q     <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            drain_q     <= drain_d;
            from_step_q <= from_step_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
        end
    end

    assign cmd.cmd_ready_o = ready;
    assign fetch_en_o      = (state_q == S_RUN) || (state_q == S_STEP);
    assign pipe_en_o       = pipe_en;
    assign core_flush_o    = (state_q == S_CORE_RST);
    assign state_o         = state_q;
    assign halted_o        = (state_q == S_HALTED);
    assign halt_cause_o    = cause_q;
    assign cycle_cnt_o     = cycle_q;
    assign instret_cnt_o   = instret_q;

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Run-control sequencer for the pipelined RV32I core. Gates fetch and pipeline advance, executes debug commands (run, single-step, halt, core reset) and drains the pipeline on debug halt.
- Stops the core when an ecall (is_halt from the control decoder, carried to WB) retires.
- Maintains cycle and retired-instruction counters for the debug host.

Parameters:
- DRAIN_CYCLES, 4, cycles the pipeline advances with fetch gated so in-flight instructions retire (≥1).
- CNT_W, 32, width of both performance counters.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  asynchronous active-high reset
- cmd_valid_i  input  1  debug command valid
- cmd_ready_o  output  1  sequencer can accept a command
- cmd_op_i  input  2  00=RUN, 01=STEP, 10=HALT, 11=RESET_CORE
- wb_is_halt_i  input  1  ecall in WB this cycle
- wb_retire_i  input  1  valid (non-bubble) instruction in WB this cycle
- fetch_en_o  output  1  1=PC advances and IF issues; 0=IF injects NOP, PC holds
- pipe_en_o  output  1  1=all pipeline registers advance; 0=freeze
- core_flush_o  output  1  one-cycle pulse: PC to reset vector, pipeline registers to NOP
- state_o  output  3  current FSM state encoding
- halted_o  output  1  state==HALTED
- halt_cause_o  output  2  00=none, 01=ecall, 10=debug HALT, 11=step done
- cycle_cnt_o  output  CNT_W  cycles with pipe_en_o=1
- instret_cnt_o  output  CNT_W  retired instructions

Behaviour:
- Reset (async, immediate): state IDLE, fetch_en_o=0, pipe_en_o=0, core_flush_o=0, halted_o=0, halt_cause_o=00, both counters 0, cmd_ready_o=1.
- State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4, CORE_RST=5. All outputs are Moore, decoded from registered state.
- Handshake: a command is accepted at the rising edge where cmd_valid_i && cmd_ready_o. The new state is visible the next cycle.
- cmd_ready_o=1 in IDLE, RUN and HALTED; 0 in STEP, DRAIN and CORE_RST.
- Enables by state:
  - IDLE, HALTED, CORE_RST: fetch_en_o=0, pipe_en_o=0.
  - RUN, STEP: fetch_en_o=1, pipe_en_o=1.
  - DRAIN: fetch_en_o=0, pipe_en_o=1.
- IDLE:
  - RUN → RUN, cause cleared to 00.
  - STEP → STEP, cause cleared to 00.
  - HALT → accepted, no effect.
  - RESET_CORE → CORE_RST.
- RUN:
  - HALT → DRAIN (debug drain).
  - RESET_CORE → CORE_RST.
  - RUN or STEP → accepted, no effect.
- STEP: exactly 1 cycle (one instruction fetched), then DRAIN (step drain).
- DRAIN:
  - Lasts exactly DRAIN_CYCLES cycles, counted by an internal down-counter loaded on entry.
  - Then → HALTED, with cause 10 for a debug drain or 11 for a step drain.
- HALTED, cause ≠ 01:
  - RUN → RUN; STEP → STEP; both clear cause to 00.
  - HALT → no effect.
  - RESET_CORE → CORE_RST.
- HALTED, cause = 01: only RESET_CORE leaves the state. RUN, STEP and HALT are accepted and ignored.
- CORE_RST:
  - Lasts exactly 1 cycle, with core_flush_o=1.
  - Both counters and the cause are cleared at the end of this cycle.
  - Next state is IDLE.
- Ecall: wb_is_halt_i=1 in RUN, STEP or DRAIN → HALTED next cycle with cause 01.
  - pipe_en_o drops that same next cycle; instructions younger than the ecall stay frozen, unretired.
  - This overrides any command accepted in the same cycle and any pending drain completion.
  - wb_is_halt_i is ignored in IDLE, HALTED and CORE_RST.
- Counters:
  - cycle_cnt increments on each edge where pipe_en_o=1.
  - instret_cnt increments on edges where pipe_en_o=1 && wb_retire_i=1. The ecall itself counts as retired.
  - Both wrap modulo 2^CNT_W with no saturation and no flag.
- rst_i asserted mid-STEP or mid-DRAIN: immediate return to reset values; the drain counter is also cleared.

Test Plan:
- Reset, then RUN, DRAIN_CYCLES=4, wb_retire_i=1 constant for 10 cycles → state_o=1, fetch_en_o=pipe_en_o=1, cycle_cnt_o=10, instret_cnt_o=10.
- In RUN, issue HALT → fetch_en_o=0 and pipe_en_o=1 for exactly 4 cycles, then halted_o=1, halt_cause_o=10, pipe_en_o=0. A following RUN resumes with cause 00.
- From HALTED, issue STEP → fetch_en_o=1 for exactly 1 cycle, then 4 DRAIN cycles, then HALTED with cause 11. cmd_ready_o=0 for those 5 cycles.
- In RUN, pulse wb_is_halt_i with HALT accepted the same cycle → HALTED next cycle, cause 01. A subsequent RUN leaves state at 4. RESET_CORE gives one-cycle core_flush_o=1, then IDLE with counters 0.
- CNT_W=4, run 17 cycles with retire=1 → cycle_cnt_o=1, instret_cnt_o=1 (wrap).
- Assert rst_i asynchronously in DRAIN cycle 2 → all outputs at reset values before the next edge. After release, state_o=0.
